// File: rtl/fb_scanout_if.sv
// Framebuffer read port plus display pixel stream for fb_scanout.
// Coordinate widths follow FB_SCANOUT_PIXEL_DOUBLE_EN (half-size framebuffer when defined).
interface fb_scanout_if #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240
);
`ifdef FB_SCANOUT_PIXEL_DOUBLE_EN
    localparam int X_W = $clog2(H_ACTIVE / 2);
    localparam int Y_W = $clog2(V_ACTIVE / 2);
`else
    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE);
`endif

    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [15:0]    pixel_in;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic [15:0]    rgb_out;
    logic           frame_start;

    modport master (
        output x_out, y_out, hsync, vsync, de, rgb_out, frame_start,
        input  pixel_in
    );

    modport slave (
        input  x_out, y_out, hsync, vsync, de, rgb_out, frame_start,
        output pixel_in
    );
endinterface

// File: rtl/fb_scanout.sv
// Raster timing generator and framebuffer reader for the display clock domain.
// Optional FB_SCANOUT_PIXEL_DOUBLE_EN: scan a half-size framebuffer with 2x2 pixel replication.
module fb_scanout #(
    parameter int   H_ACTIVE   = 320,
    parameter int   H_FP       = 8,
    parameter int   H_SYNC     = 32,
    parameter int   H_BP       = 40,
    parameter int   V_ACTIVE   = 240,
    parameter int   V_FP       = 3,
    parameter int   V_SYNC     = 4,
    parameter int   V_BP       = 6,
    parameter int   RD_LATENCY = 1,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    fb_scanout_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare state so the sync end bound still fits when the back porch is zero.
    localparam int HC_W = $clog2(H_TOTAL + 1);
    localparam int VC_W = $clog2(V_TOTAL + 1);
`ifdef FB_SCANOUT_PIXEL_DOUBLE_EN
    localparam int X_W = $clog2(H_ACTIVE / 2);
    localparam int Y_W = $clog2(V_ACTIVE / 2);
`else
    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE);
`endif

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG   = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG   = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic fs;
    } tmg_t;

    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;
    logic [HC_W-1:0] h_idx;
    logic [VC_W-1:0] v_idx;
    tmg_t            st0;
    tmg_t            pipe [RD_LATENCY+1];
    logic [15:0]     rgb_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        st0       = '0;
        bus.x_out = '0;
        bus.y_out = '0;
`ifdef FB_SCANOUT_PIXEL_DOUBLE_EN
        h_idx     = h_cnt >> 1;
        v_idx     = v_cnt >> 1;
`else
        h_idx     = h_cnt;
        v_idx     = v_cnt;
`endif
        st0.active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        st0.hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        st0.vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        st0.fs     = st0.active && (h_cnt == '0) && (v_cnt == '0);
        // Blanking reads are parked at (0,0) so the RAM is never addressed out of range.
        if (st0.active) begin
            bus.x_out = h_idx[X_W-1:0];
            bus.y_out = v_idx[Y_W-1:0];
        end
    end

    // Timing bits ride alongside the RAM access; rgb_q closes the last stage with the read data.
    // NOTE: this small register array is reset element by element; large storage arrays would not be.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= RD_LATENCY; i++) pipe[i] <= '0;
            rgb_q <= '0;
        end else begin
            pipe[0] <= st0;
            for (int i = 1; i <= RD_LATENCY; i++) pipe[i] <= pipe[i-1];
            rgb_q <= pipe[RD_LATENCY-1].active ? bus.pixel_in : 16'h0000;
        end
    end

    assign bus.de          = pipe[RD_LATENCY].active;
    assign bus.hsync       = pipe[RD_LATENCY].hs ? SYNC_POL : ~SYNC_POL;
    assign bus.vsync       = pipe[RD_LATENCY].vs ? SYNC_POL : ~SYNC_POL;
    assign bus.frame_start = pipe[RD_LATENCY].fs;
    assign bus.rgb_out     = rgb_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: two small-raster instances (read latency 1 and 3, both sync polarities)
// against a random framebuffer, with a pixel scoreboard and an arithmetic raster model.
module tb_fb_scanout;
`ifdef FB_SCANOUT_PIXEL_DOUBLE_EN
    localparam int HA    = 8;
    localparam int VA    = 4;
    localparam int SCALE = 2;
`else
    localparam int HA    = 4;
    localparam int VA    = 3;
    localparam int SCALE = 1;
`endif
    localparam int HFP = 1, HS = 2, HBP = 1;
    localparam int VFP = 1, VS = 1, VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int F   = HT * VT;
    localparam int FB_W = HA / SCALE;
    localparam int FB_H = VA / SCALE;
    localparam int LA = 1;
    localparam int LB = 3;
    localparam bit POL_A = 1'b0;
    localparam bit POL_B = 1'b1;

    typedef struct packed {
        logic [15:0] rgb;
        logic        first;
    } exp_px_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   e = 0;
    int   n_checks = 0;
    int   n_err = 0;

    logic [15:0] fb   [FB_H][FB_W];
    logic [15:0] rd_a [LA];
    logic [15:0] rd_b [LB];
    exp_px_t     qa [$];
    exp_px_t     qb [$];

    fb_scanout_if #(.H_ACTIVE(HA), .V_ACTIVE(VA)) bus_a ();
    fb_scanout_if #(.H_ACTIVE(HA), .V_ACTIVE(VA)) bus_b ();

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .RD_LATENCY(LA), .SYNC_POL(POL_A)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .RD_LATENCY(LB), .SYNC_POL(POL_B)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Edges seen since reset release; the raster position is a pure function of this count.
    always @(posedge clk) begin
        if (!rst) e <= 0;
        else      e <= e + 1;
    end

    function automatic logic [15:0] ram_rd(input int x, input int y);
        if (x < FB_W && y < FB_H) return fb[y][x];
        return 16'hBAD0;
    endfunction

    // Framebuffer RAM model: data appears exactly the configured number of clocks after the address.
    always @(posedge clk) begin
        rd_a[0] <= ram_rd(int'(bus_a.x_out), int'(bus_a.y_out));
        rd_b[0] <= ram_rd(int'(bus_b.x_out), int'(bus_b.y_out));
        for (int i = 1; i < LA; i++) rd_a[i] <= rd_a[i-1];
        for (int i = 1; i < LB; i++) rd_b[i] <= rd_b[i-1];
    end
    assign bus_a.pixel_in = rd_a[LA-1];
    assign bus_b.pixel_in = rd_b[LB-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected {de, hsync, vsync, frame_start} after e_now edges for a given output latency.
    function automatic logic [3:0] exp_tmg(input int e_now, input int lat, input bit pol);
        int k, pos, h, v;
        bit de, hs, vs, fs;
        k = e_now - (lat + 1);
        de = 0; hs = 0; vs = 0; fs = 0;
        if (k >= 0) begin
            pos = k % F;
            h   = pos % HT;
            v   = pos / HT;
            de  = (h < HA) && (v < VA);
            hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
            vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
            fs  = de && (pos == 0);
        end
        return {de, hs ? pol : !pol, vs ? pol : !pol, fs};
    endfunction

    function automatic void exp_xy(input int e_now, output int x, output int y);
        int pos, h, v;
        pos = e_now % F;
        h = pos % HT;
        v = pos / HT;
        x = 0;
        y = 0;
        if (h < HA && v < VA) begin
            x = h / SCALE;
            y = v / SCALE;
        end
    endfunction

    // Raster/timing monitor: every cycle, both instances against the arithmetic model.
    always @(negedge clk) begin
        logic [3:0] t_a, t_b;
        int ex, ey;
        if (!rst) begin
            check("rst_de_a", bus_a.de, 0);
            check("rst_hsync_a", bus_a.hsync, !POL_A);
            check("rst_vsync_a", bus_a.vsync, !POL_A);
            check("rst_fs_a", bus_a.frame_start, 0);
            check("rst_rgb_a", bus_a.rgb_out, 0);
            check("rst_hsync_b", bus_b.hsync, !POL_B);
            check("rst_vsync_b", bus_b.vsync, !POL_B);
            check("rst_de_b", bus_b.de, 0);
            check("rst_rgb_b", bus_b.rgb_out, 0);
        end else begin
            t_a = exp_tmg(e, LA, POL_A);
            t_b = exp_tmg(e, LB, POL_B);
            check("de_a", bus_a.de, t_a[3]);
            check("hsync_a", bus_a.hsync, t_a[2]);
            check("vsync_a", bus_a.vsync, t_a[1]);
            check("fs_a", bus_a.frame_start, t_a[0]);
            if (!t_a[3]) check("blank_rgb_a", bus_a.rgb_out, 0);
            check("de_b", bus_b.de, t_b[3]);
            check("hsync_b", bus_b.hsync, t_b[2]);
            check("vsync_b", bus_b.vsync, t_b[1]);
            check("fs_b", bus_b.frame_start, t_b[0]);
            if (!t_b[3]) check("blank_rgb_b", bus_b.rgb_out, 0);
            exp_xy(e, ex, ey);
            check("x_a", bus_a.x_out, ex);
            check("y_a", bus_a.y_out, ey);
            check("x_b", bus_b.x_out, ex);
            check("y_b", bus_b.y_out, ey);
        end
    end

    // Scoreboard monitor: each visible pixel pops the next expected framebuffer word.
    always @(negedge clk) begin
        exp_px_t p;
        if (rst && bus_a.de) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_a_underflow: rgb_out=0x%0h, expected no pixel at t=%0t", bus_a.rgb_out, $time);
            end else begin
                p = qa.pop_front();
                check("sb_rgb_a", bus_a.rgb_out, p.rgb);
                check("sb_fs_a", bus_a.frame_start, p.first);
            end
        end
        if (rst && bus_b.de) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_b_underflow: rgb_out=0x%0h, expected no pixel at t=%0t", bus_b.rgb_out, $time);
            end else begin
                p = qb.pop_front();
                check("sb_rgb_b", bus_b.rgb_out, p.rgb);
                check("sb_fs_b", bus_b.frame_start, p.first);
            end
        end
    end

    task automatic randomize_fb();
        for (int y = 0; y < FB_H; y++)
            for (int x = 0; x < FB_W; x++) begin
                fb[y][x] = 16'($urandom);
                if (fb[y][x] == 16'h0000) fb[y][x] = 16'h0001;
            end
    endtask

    task automatic push_frames(input int n);
        exp_px_t p;
        for (int f = 0; f < n; f++)
            for (int v = 0; v < VA; v++)
                for (int h = 0; h < HA; h++) begin
                    p.rgb   = fb[v / SCALE][h / SCALE];
                    p.first = (h == 0) && (v == 0);
                    qa.push_back(p);
                    qb.push_back(p);
                end
    endtask

    task automatic release_rst(input int frames);
        @(posedge clk);
        #2;
        rst = 1'b1;
        push_frames(frames);
    endtask

    // Called between edges: outputs must fall to idle without waiting for a clock.
    task automatic assert_rst(input bit expect_drained);
        if (expect_drained) begin
            check("sb_drained_a", qa.size(), 0);
            check("sb_drained_b", qb.size(), 0);
        end
        rst = 1'b0;
        #1;
        check("async_de_a", bus_a.de, 0);
        check("async_hsync_a", bus_a.hsync, !POL_A);
        check("async_vsync_a", bus_a.vsync, !POL_A);
        check("async_rgb_a", bus_a.rgb_out, 0);
        check("async_fs_a", bus_a.frame_start, 0);
        check("async_x_a", bus_a.x_out, 0);
        check("async_y_a", bus_a.y_out, 0);
        check("async_hsync_b", bus_b.hsync, !POL_B);
        check("async_de_b", bus_b.de, 0);
        qa.delete();
        qb.delete();
        randomize_fb();
    endtask

    initial begin
        int first_a, first_b, r;
        randomize_fb();
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Free run over several whole frames.
        release_rst(3);
        repeat (3 * F) @(posedge clk);
        #2 assert_rst(1'b1);
        repeat (3) @(posedge clk);

        // Reset in the middle of line 1, counter at h=2.
        release_rst(2);
        repeat (F + HT + 2) @(posedge clk);
        #2 assert_rst(1'b0);
        repeat (3) @(posedge clk);

        // Restart: first frame_start must land latency+1 edges after release.
        release_rst(2);
        first_a = -1;
        first_b = -1;
        for (int i = 1; i <= 2 * F; i++) begin
            @(posedge clk);
            #1;
            if (bus_a.frame_start && first_a < 0) first_a = i;
            if (bus_b.frame_start && first_b < 0) first_b = i;
        end
        check("fs_latency_a", first_a, LA + 1);
        check("fs_latency_b", first_b, LB + 1);
        #1 assert_rst(1'b1);
        repeat (2) @(posedge clk);

        // Resets at random points in the raster.
        for (int n = 0; n < 4; n++) begin
            release_rst(4);
            r = $urandom_range(4 * F - 1, 1);
            repeat (r) @(posedge clk);
            #2 assert_rst(1'b0);
            repeat (2) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Display-side reader for the 320x240 RGB565 framebuffer dual-port RAM. The video generator writes that RAM on the logic clock.
- Runs in the display clock domain and generates raster timing: horizontal/vertical counters, hsync, vsync, data-enable.
- Drives the RAM read coordinates and re-aligns the returned pixel with the delayed timing signals.
- Presents a registered, display-ready pixel stream to the panel/encoder.

Parameters:
- H_ACTIVE, 320, visible pixels per line
- H_FP, 8, horizontal front porch (clocks)
- H_SYNC, 32, hsync width (clocks)
- H_BP, 40, horizontal back porch (clocks)
- V_ACTIVE, 240, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 6, vertical back porch (lines)
- RD_LATENCY, 1, framebuffer read latency in clocks (1..4)
- SYNC_POL, 0, active level of hsync/vsync

Ports:
- clk  in  1  display clock
- rst  in  1  reset, asynchronous, active-low
- x_out  out  $clog2(H_ACTIVE)  framebuffer read x coordinate
- y_out  out  $clog2(V_ACTIVE)  framebuffer read y coordinate
- pixel_in  in  16  RGB565 read data, valid RD_LATENCY clocks after x_out/y_out
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, high on visible pixels
- rgb_out  out  16  RGB565 pixel to display
- frame_start  out  1  one-clock pulse coincident with first visible pixel of each frame

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1.
  - h_cnt increments every clock and wraps to 0.
  - v_cnt increments when h_cnt wraps; wraps to 0 after V_TOTAL-1.
  - Simultaneous h and v wrap returns both to 0 on the same edge.
- Stage 0 (counter stage):
  - active0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs0 = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs0 = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), held for whole lines.
  - fs0 = active0 && h_cnt==0 && v_cnt==0.
- x_out/y_out:
  - Equal h_cnt/v_cnt truncated to port width while active0.
  - Held at 0 outside active0, so reads stay in range.
- Pipeline: active0, hs0, vs0, fs0 travel through a RD_LATENCY+1 deep register pipeline.
  - Outputs: de, hsync (=hs ? SYNC_POL : ~SYNC_POL), vsync (same rule), frame_start.
  - rgb_out registered from pixel_in when the delayed active bit is 1, else 16'h0000.
  - Total latency, counter state to outputs: RD_LATENCY+1 clocks. pixel_in sampled exactly RD_LATENCY clocks after its address.
- Reset (rst=0, async):
  - Counters 0; whole pipeline cleared.
  - de=0, frame_start=0, rgb_out=0, x_out=0, y_out=0.
  - hsync=vsync=~SYNC_POL immediately, without a clock.
  - Reset mid-line or mid-frame: same behaviour, no partial-frame recovery.
  - After release: first clock edge starts h_cnt advance; first frame_start/de at output RD_LATENCY+1 clocks after the first post-release edge.
- No handshake/backpressure: the pixel stream is free-running; pixel_in must meet RD_LATENCY.

Optional Feature:
- Macro: FB_SCANOUT_PIXEL_DOUBLE_EN.
- Defined:
  - x_out = h_cnt>>1, y_out = v_cnt>>1; each framebuffer pixel appears on 2 adjacent clocks and each line on 2 output lines.
  - H_ACTIVE/V_ACTIVE denote output raster size (e.g. 640x480 from a 320x240 buffer).
  - x_out/y_out widths become $clog2(H_ACTIVE/2)/$clog2(V_ACTIVE/2).
- Undefined: 1:1 mapping as above.

Test Plan:
- Default params, free run 3 frames -> frame_start period 400*253 = 101200 clocks; hsync at SYNC_POL for 32 of every 400 clocks; vsync active for 4*400 = 1600 clocks per frame; de high 320 clocks/line on 240 lines.
- Small raster:
  - Params: H=4/1/2/1, V=3/1/1/1; RAM model returns y*4+x with RD_LATENCY=1.
  - Expected: rgb_out during de = 0..11 in order; de high 4 of every 8 clocks; frame period 48 clocks.
- Blanking: pixel_in forced 16'hFFFF -> rgb_out = 0 on every de=0 clock; x_out=y_out=0 whenever outside visible region.
- Reset mid-line:
  - Stimulus: small raster, drive rst=0 at h_cnt=2, v_cnt=1.
  - Expected: de=0, hsync=vsync=1 (SYNC_POL=0), rgb_out=0 before next edge; after release, frame_start exactly 2 clocks after the first edge; sequence restarts at 0.
- RD_LATENCY=3, small raster -> same 0..11 sequence aligned to de; frame_start at first pixel 4 clocks after counter origin.
- FB_SCANOUT_PIXEL_DOUBLE_EN, small raster H_ACTIVE=8, V_ACTIVE=4 -> rgb_out line pattern 0,0,1,1,2,2,3,3, each line repeated twice, then 4,4,5,5,...
